// File: rtl/fft_frame_streamer_if.sv
// Stream bundle for fft_frame_streamer: 4-mic sample input on one side,
// 128-bit FFT beats plus status on the other.
//
// Handshake: a beat transfers on every rising clock edge where
// fft_valid_out and fft_ready_in are both high. Once fft_valid_out is
// raised it stays high, with fft_data_out and fft_last_out unchanged,
// until that transfer happens. audio_valid_in has no back-pressure:
// each high cycle offers exactly one sample set, taken or counted as dropped.
interface fft_frame_streamer_if #(
  parameter int DROP_CNT_WIDTH = 16
);
  logic [63:0]               audio_data_in;
  logic                      audio_valid_in;
  logic [127:0]              fft_data_out;
  logic                      fft_valid_out;
  logic                      fft_last_out;
  logic                      fft_ready_in;
  logic                      frame_active_out;
  logic [DROP_CNT_WIDTH-1:0] dropped_samples_out;

  modport master (
    input  audio_data_in, audio_valid_in, fft_ready_in,
    output fft_data_out, fft_valid_out, fft_last_out,
           frame_active_out, dropped_samples_out
  );

  modport slave (
    output audio_data_in, audio_valid_in, fft_ready_in,
    input  fft_data_out, fft_valid_out, fft_last_out,
           frame_active_out, dropped_samples_out
  );
endinterface

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: collects 4-channel mic sample sets into two ping-pong
// frame banks and streams each full frame as 128-bit beats to the FFT core.
// Optional build macro HANN_WINDOW_EN applies a Hann window on the read path.
// Reader FSM state is visible on dbg_state (0 idle, 1 fetch, 2 stream).
module fft_frame_streamer #(
  parameter int FFT_SIZE       = 512,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  fft_frame_streamer_if.master bus,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W = $clog2(FFT_SIZE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } rd_state_t;

  // frame storage, addressed as {bank, index}
  logic [63:0] mem [2*FFT_SIZE];

  // write side
  logic                      wr_bank;
  logic [IDX_W-1:0]          wr_idx;
  logic                      wr_ok;
  logic                      wr_en;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt;
  logic [1:0]                bank_full;
  logic [1:0]                full_set;
  logic [1:0]                full_clr;

  // read side
  rd_state_t        state;
  rd_state_t        state_next;
  logic             rd_bank;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_all_issued;
  logic             rd_en;
  logic             iss_bank;
  logic [IDX_W-1:0] iss_idx;
  logic             rd_pending;
  logic             rd_pend_last;
  logic [63:0]      rd_q;
  logic [63:0]      load_data;

  // output register plus one-entry skid so a stall never loses a fetched beat
  logic        out_valid;
  logic        out_last;
  logic [63:0] out_data;
  logic        skid_valid;
  logic        skid_last;
  logic [63:0] skid_data;
  logic        frame_active;

  logic       pop;
  logic       last_hs;
  logic [1:0] occ;
  logic       space;

  assign pop     = out_valid & bus.fft_ready_in;
  assign last_hs = pop & out_last;
  assign occ     = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending);
  // a new read may go out if at most one beat stays buffered after this edge
  assign space   = (occ - 2'(pop)) < 2'd2;

  // a bank being released by the reader this very cycle is already writable
  assign wr_ok = !bank_full[wr_bank] || (last_hs && (rd_bank == wr_bank));
  assign wr_en = bus.audio_valid_in && wr_ok;

  assign full_set = (wr_en && (wr_idx == LAST_IDX)) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = last_hs ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

`ifdef HANN_WINDOW_EN
  function automatic logic [15:0] hann_coef(input int i);
    real v;
    v = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979 * real'(i) / real'(FFT_SIZE)));
    return 16'($rtoi(v + 0.5));
  endfunction

  function automatic logic [15:0] apply_win(input logic [15:0] s, input logic [15:0] w);
    logic signed [33:0] p;
    p = $signed(s) * $signed({1'b0, w}) + 34'sd32768;
    return p[31:16];
  endfunction

  logic [15:0] hann_rom [FFT_SIZE];
  logic [15:0] rd_coef;

  for (genvar i = 0; i < FFT_SIZE; i++) begin : g_hann
    localparam logic [15:0] W = hann_coef(i);
    assign hann_rom[i] = W;
  end

  // coefficient fetched alongside the sample so both arrive together
  always_ff @(posedge clk_in) begin
    if (rd_en) rd_coef <= hann_rom[iss_idx];
  end

  // window all four channels of the fetched sample set
  always_comb begin
    load_data = '0;
    for (int c = 0; c < 4; c++) begin
      load_data[16*c +: 16] = apply_win(rd_q[16*c +: 16], rd_coef);
    end
  end
`else
  assign load_data = rd_q;
`endif

  // frame RAM: one write port from the mic side, one read port for the stream
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[{wr_bank, wr_idx}] <= bus.audio_data_in;
    if (rd_en) rd_q <= mem[{iss_bank, iss_idx}];
  end

  // write pointer and saturating drop counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_bank  <= 1'b0;
      wr_idx   <= '0;
      drop_cnt <= '0;
    end else if (bus.audio_valid_in) begin
      if (wr_ok) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_idx <= wr_idx + IDX_W'(1);
        end
      end else if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
      end
    end
  end

  // bank occupancy: set when the writer completes a bank, cleared on its last beat
  always_ff @(posedge clk_in) begin
    if (rst_in) bank_full <= 2'b00;
    else        bank_full <= (bank_full & ~full_clr) | full_set;
  end

  // reader state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_next;
  end

  // reader next-state: banks are read alternately, which is also fill order
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (bank_full[rd_bank]) state_next = S_FETCH;
      S_FETCH:  state_next = S_STREAM;
      S_STREAM: if (last_hs) state_next = bank_full[~rd_bank] ? S_FETCH : S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // reader outputs: which RAM read to issue this cycle
  always_comb begin
    rd_en    = 1'b0;
    iss_bank = rd_bank;
    iss_idx  = rd_idx;
    case (state)
      S_IDLE: begin
        if (bank_full[rd_bank]) begin
          rd_en   = 1'b1;
          iss_idx = '0;
        end
      end
      S_FETCH, S_STREAM: begin
        if (last_hs) begin
          if (bank_full[~rd_bank]) begin
            rd_en    = 1'b1;
            iss_bank = ~rd_bank;
            iss_idx  = '0;
          end
        end else if (!rd_all_issued && space) begin
          rd_en = 1'b1;
        end
      end
      default: rd_en = 1'b0;
    endcase
  end

  // read bookkeeping: next index, in-flight flag, active bank
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_bank       <= 1'b0;
      rd_idx        <= '0;
      rd_all_issued <= 1'b0;
      rd_pending    <= 1'b0;
      rd_pend_last  <= 1'b0;
    end else begin
      rd_pending <= rd_en;
      if (rd_en) begin
        rd_pend_last  <= (iss_idx == LAST_IDX);
        rd_all_issued <= (iss_idx == LAST_IDX);
        rd_idx        <= iss_idx + IDX_W'(1);
      end
      if (last_hs) rd_bank <= ~rd_bank;
    end
  end

  // output and skid registers: data returning from RAM lands here in order
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_last   <= skid_last;
        out_data   <= skid_data;
        skid_valid <= rd_pending;
        skid_last  <= rd_pend_last;
        skid_data  <= load_data;
      end else begin
        out_valid <= rd_pending;
        out_last  <= rd_pending & rd_pend_last;
        if (rd_pending) out_data <= load_data;
      end
    end else if (rd_pending) begin
      skid_valid <= 1'b1;
      skid_last  <= rd_pend_last;
      skid_data  <= load_data;
    end
  end

  // frame_active rises with the first beat and falls after the last handshake
  always_ff @(posedge clk_in) begin
    if (rst_in)                frame_active <= 1'b0;
    else if (last_hs)          frame_active <= 1'b0;
    else if (state == S_FETCH) frame_active <= 1'b1;
  end

  assign bus.fft_valid_out       = out_valid;
  assign bus.fft_last_out        = out_last;
  assign bus.fft_data_out        = {16'h0, out_data[63:48], 16'h0, out_data[47:32],
                                    16'h0, out_data[31:16], 16'h0, out_data[15:0]};
  assign bus.frame_active_out    = frame_active;
  assign bus.dropped_samples_out = drop_cnt;
  assign dbg_state               = state;

endmodule
